dsky_channel_if: RTL and testbench
==================================

DSKY_CHANNEL_IF -- requirements
Module: dsky_channel_if

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter FIFO_DEPTH, default 4: key FIFO entries, power of two, 2..16.
REQ-003 Parameter KEY_CH, default 13 (octal 015): channel number that pops a keycode.
REQ-004 Parameter DISP_CH, default 8 (octal 010): channel number for display relay words.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 key_valid  in  1  keypad presents a keycode.
REQ-008 key_code  in  5  keypad code.
REQ-009 key_ready  out  1  block accepts a keycode this cycle.
REQ-010 ch_addr  in  7  CPU I/O channel number.
REQ-011 ch_rd  in  1  CPU channel read strobe, one cycle.
REQ-012 ch_wr  in  1  CPU channel write strobe, one cycle.
REQ-013 ch_wdata  in  16  CPU write word, bit 15 = parity.
REQ-014 ch_rdata  out  16  registered read data, bit 15 = parity.
REQ-015 keyrupt  out  1  key interrupt request to CPU.
REQ-016 keyrupt_ack  in  1  CPU accepted the interrupt, one-cycle pulse.
REQ-017 disp_word  out  15  latched display relay word.
REQ-018 disp_strobe  out  1  one-cycle pulse when disp_word updates.
REQ-019 overflow  out  1  sticky: a key was refused while the FIFO was full.
REQ-020 parity_err  out  1  one-cycle pulse: a display write was rejected for parity.

Function
REQ-021 Push: key_valid && key_ready SHALL write key_code to the FIFO tail; key_ready SHALL equal !full.
REQ-022 key_valid while full SHALL drop the code and set overflow until reset; a pop in the same cycle SHALL NOT make room for it.
REQ-023 A read with ch_rd && ch_addr==KEY_CH on a non-empty FIFO SHALL pop the head; the next cycle ch_rdata[14:0] SHALL be {10'b0, code}.
REQ-024 The same read on an empty FIFO SHALL return zero and leave the FIFO unchanged.
REQ-025 A push and a pop in the same cycle on a non-empty, non-full FIFO SHALL leave the count unchanged and keep order.
REQ-026 A read of DISP_CH SHALL return {0, disp_word} the next cycle; any other channel SHALL return zero; ch_rdata SHALL hold its value until the next ch_rd.
REQ-027 A write with ch_wr && ch_addr==DISP_CH SHALL latch ch_wdata[14:0] into disp_word and pulse disp_strobe the next cycle; writes to other channels SHALL be ignored.
REQ-028 If ch_rd and ch_wr are both asserted in one cycle, the block SHALL perform both, and a DISP_CH read SHALL return the old disp_word.
REQ-029 The interrupt FSM SHALL have three states:
- IDLE: keyrupt=0.
- REQ: keyrupt=1.
- SERVICE: keyrupt=0.
REQ-030 IDLE->REQ when the FIFO is non-empty; REQ->SERVICE on keyrupt_ack; SERVICE->REQ or IDLE on a KEY_CH read, per FIFO occupancy after the pop.
REQ-031 keyrupt SHALL be registered and asserted the cycle after the FSM enters REQ; keyrupt_ack outside REQ SHALL be ignored.

Reset
REQ-032 While rst_n is low, the block SHALL force:
- FIFO empty, key_ready=1.
- ch_rdata=0, disp_word=0, disp_strobe=0.
- keyrupt=0, overflow=0, parity_err=0.
- FSM in IDLE.
REQ-033 Reset asserted mid-transaction SHALL discard FIFO contents and any pending interrupt immediately, without waiting for a clock edge.

Configuration
REQ-034 The macro DSKY_CHANNEL_PARITY_EN SHALL control parity handling.
REQ-035 With DSKY_CHANNEL_PARITY_EN defined:
- ch_rdata[15] SHALL be the odd-parity bit of ch_rdata[14:0].
- A DISP_CH write whose 16-bit ch_wdata has even parity SHALL be discarded and SHALL pulse parity_err instead of disp_strobe.
REQ-036 Without DSKY_CHANNEL_PARITY_EN:
- ch_rdata[15] SHALL be 0.
- ch_wdata[15] SHALL be ignored.
- parity_err SHALL be constant 0.

Verification
REQ-037 Push key 5'h11 -> keyrupt rises within 2 cycles; ack, then read ch 13 -> ch_rdata[4:0]=5'h11, keyrupt stays 0, FSM returns to IDLE.
REQ-038 Push 5 keys with no reads (FIFO_DEPTH 4) -> key_ready=0 after the 4th, overflow=1; 4 reads return the first 4 codes in order, the 5th read returns 0.
REQ-039 Write 16'h0123 to ch 8 (macro off) -> disp_word=15'h0123 with a one-cycle disp_strobe; a read of ch 8 returns 16'h0123.
REQ-040 Macro on, write 16'h0003 (even parity) to ch 8 -> disp_word unchanged, parity_err pulses; write 16'h8003 -> disp_word=15'h0003, and a read returns bit 15=1.
REQ-041 Push 2 keys, ack, assert rst_n=0 mid-cycle -> keyrupt=0 and FIFO empty without a clock edge; a read of ch 13 after reset returns 0.

Source files
------------

// File: rtl/dsky_channel_if.sv
// DSKY channel interface: keypad FIFO, CPU channel read/write port, display relay latch and key interrupt FSM.
// Define DSKY_CHANNEL_PARITY_EN to generate read parity and reject even-parity display writes.
module dsky_channel_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int KEY_CH     = 13,
    parameter int DISP_CH    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic        key_ready,
    input  logic [6:0]  ch_addr,
    input  logic        ch_rd,
    input  logic        ch_wr,
    input  logic [15:0] ch_wdata,
    output logic [15:0] ch_rdata,
    output logic        keyrupt,
    input  logic        keyrupt_ack,
    output logic [14:0] disp_word,
    output logic        disp_strobe,
    output logic        overflow,
    output logic        parity_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dsky_channel_if: FIFO_DEPTH must be a power of two in 2..16");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    logic [4:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             full;
    logic             empty;
    logic             key_sel;
    logic             disp_sel;
    logic             push;
    logic             pop;
    logic             key_rd;
    logic [14:0]      rd_word;
    logic             rd_par;
    logic             wr_par_ok;
    irq_state_t       state;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign key_ready = !full;
    assign key_sel   = (ch_addr == 7'(KEY_CH));
    assign disp_sel  = (ch_addr == 7'(DISP_CH));
    assign key_rd    = ch_rd && key_sel;

    // A full FIFO refuses the key even when a pop frees a slot in the same cycle.
    assign push = key_valid && !full;
    assign pop  = key_rd && !empty;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_comb begin
        rd_word = '0;
        if (key_sel) begin
            if (!empty) begin
                rd_word = {10'b0, mem[rd_ptr]};
            end
        end else if (disp_sel) begin
            rd_word = disp_word;
        end
    end

`ifdef DSKY_CHANNEL_PARITY_EN
    // Odd parity over the full 16-bit word: bit 15 makes the total count of ones odd.
    assign rd_par    = ~^rd_word;
    assign wr_par_ok = ^ch_wdata;
`else
    logic unused_wdata_par;
    assign unused_wdata_par = ch_wdata[15];
    assign rd_par           = 1'b0;
    assign wr_par_ok        = 1'b1;
`endif

    // NOTE: the key storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= key_code;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            ch_rdata    <= '0;
            disp_word   <= '0;
            disp_strobe <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (key_valid && full) begin
                overflow <= 1'b1;
            end

            // A simultaneous DISP_CH write lands on the same edge, so the read sees the old word.
            if (ch_rd) begin
                ch_rdata <= {rd_par, rd_word};
            end

            disp_strobe <= 1'b0;
            parity_err  <= 1'b0;
            if (ch_wr && disp_sel) begin
                if (wr_par_ok) begin
                    disp_word   <= ch_wdata[14:0];
                    disp_strobe <= 1'b1;
                end else begin
                    parity_err  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            keyrupt <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state   <= REQ;
                        keyrupt <= 1'b1;
                    end
                end
                REQ: begin
                    if (keyrupt_ack) begin
                        state   <= SERVICE;
                        keyrupt <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (key_rd) begin
                        if (count_next != '0) begin
                            state   <= REQ;
                            keyrupt <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            keyrupt <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    keyrupt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsky_channel_if.sv
// Self-checking bench for dsky_channel_if: directed scenarios plus randomized traffic against a queue-based model.
module tb_dsky_channel_if;
    localparam int DEPTH   = 4;
    localparam int KEY_CH  = 13;
    localparam int DISP_CH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = '0;
    logic        key_ready;
    logic [6:0]  ch_addr = '0;
    logic        ch_rd = 1'b0;
    logic        ch_wr = 1'b0;
    logic [15:0] ch_wdata = '0;
    logic [15:0] ch_rdata;
    logic        keyrupt;
    logic        keyrupt_ack = 1'b0;
    logic [14:0] disp_word;
    logic        disp_strobe;
    logic        overflow;
    logic        parity_err;

    dsky_channel_if #(.FIFO_DEPTH(DEPTH), .KEY_CH(KEY_CH), .DISP_CH(DISP_CH)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .ch_addr(ch_addr), .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata),
        .keyrupt(keyrupt), .keyrupt_ack(keyrupt_ack),
        .disp_word(disp_word), .disp_strobe(disp_strobe),
        .overflow(overflow), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: key FIFO as a queue, interrupt state as 0=idle 1=requesting 2=in service.
    logic [4:0]  m_q[$];
    logic [14:0] m_disp;
    logic [15:0] m_rdata;
    logic        m_strobe, m_ovf, m_perr;
    int          m_st;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic read_par(input logic [14:0] d);
`ifdef DSKY_CHANNEL_PARITY_EN
        return ($countones(d) % 2) == 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic write_ok(input logic [15:0] w);
`ifdef DSKY_CHANNEL_PARITY_EN
        return ($countones(w) % 2) == 1;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_disp = '0; m_rdata = '0; m_strobe = 0; m_ovf = 0; m_perr = 0; m_st = 0;
    endtask

    task automatic check_all(input string where);
        check({where, ".keyrupt"},   keyrupt,     m_st == 1);
        check({where, ".key_ready"}, key_ready,   m_q.size() != DEPTH);
        check({where, ".ch_rdata"},  ch_rdata,    m_rdata);
        check({where, ".disp_word"}, disp_word,   m_disp);
        check({where, ".strobe"},    disp_strobe, m_strobe);
        check({where, ".overflow"},  overflow,    m_ovf);
        check({where, ".par_err"},   parity_err,  m_perr);
    endtask

    // One clock cycle: drive inputs, advance the model by the rules, then compare after the edge.
    task automatic cyc(input logic kv, input logic [4:0] kc, input logic rd, input logic wr,
                       input logic [6:0] addr, input logic [15:0] wd, input logic ack);
        int          n0;
        logic [14:0] w15;
        key_valid = kv; key_code = kc; ch_rd = rd; ch_wr = wr;
        ch_addr = addr; ch_wdata = wd; keyrupt_ack = ack;
        n0 = m_q.size();
        if (rd) begin
            if (addr == KEY_CH)       w15 = (n0 > 0) ? {10'b0, m_q[0]} : 15'd0;
            else if (addr == DISP_CH) w15 = m_disp;
            else                      w15 = 15'd0;
            m_rdata = {read_par(w15), w15};
        end
        m_strobe = 0; m_perr = 0;
        if (wr && addr == DISP_CH) begin
            if (write_ok(wd)) begin m_disp = wd[14:0]; m_strobe = 1; end
            else m_perr = 1;
        end
        if (kv && n0 == DEPTH) m_ovf = 1;
        if (rd && addr == KEY_CH && n0 > 0) void'(m_q.pop_front());
        if (kv && n0 != DEPTH) m_q.push_back(kc);
        case (m_st)
            0: if (n0 > 0) m_st = 1;
            1: if (ack) m_st = 2;
            default: if (rd && addr == KEY_CH) m_st = (m_q.size() > 0) ? 1 : 0;
        endcase
        @(posedge clk);
        #1;
        check_all("cyc");
    endtask

    task automatic idle();
        cyc(0, 5'd0, 0, 0, 7'd0, 16'd0, 0);
    endtask

    task automatic push(input logic [4:0] kc);
        cyc(1, kc, 0, 0, 7'd0, 16'd0, 0);
    endtask

    task automatic read_ch(input int ch);
        cyc(0, 5'd0, 1, 0, 7'(ch), 16'd0, 0);
    endtask

    task automatic write_ch(input int ch, input logic [15:0] wd);
        cyc(0, 5'd0, 0, 1, 7'(ch), wd, 0);
    endtask

    task automatic ack();
        cyc(0, 5'd0, 0, 0, 7'd0, 16'd0, 1);
    endtask

    task automatic clear_inputs();
        key_valid = 0; key_code = '0; ch_rd = 0; ch_wr = 0;
        ch_addr = '0; ch_wdata = '0; keyrupt_ack = 0;
    endtask

    // Assert reset between edges and check that everything clears without a clock edge.
    task automatic async_reset(input string tag);
        clear_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          seen;
        logic [15:0] wd;
        int          r;

        model_reset();
        #12;
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Single key through the full interrupt handshake.
        push(5'h11);
        seen = 0;
        for (int i = 0; i < 2 && !seen; i++) begin
            idle();
            if (keyrupt) seen = 1;
        end
        check("kr_rise", seen, 1'b1);
        ack();
        check("kr_after_ack", keyrupt, 1'b0);
        read_ch(KEY_CH);
        check("key_11", ch_rdata[4:0], 5'h11);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("kr_quiet", keyrupt, 1'b0);
        end

        // Overflow: five pushes into a four-entry FIFO, then drain.
        async_reset("rst_a");
        for (int i = 0; i < 5; i++) begin
            push(5'(i + 3));
            if (i == 3) check("ready_full", key_ready, 1'b0);
        end
        check("ovf_set", overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            read_ch(KEY_CH);
            check("drain_order", ch_rdata[4:0], 5'(i + 3));
        end
        read_ch(KEY_CH);
        check("drain_empty", ch_rdata[14:0], 15'd0);
        check("ovf_sticky", overflow, 1'b1);

        // Display relay word.
        async_reset("rst_b");
`ifdef DSKY_CHANNEL_PARITY_EN
        write_ch(DISP_CH, 16'h0003);
        check("par_reject_word", disp_word, 15'h0000);
        check("par_reject_err", parity_err, 1'b1);
        write_ch(DISP_CH, 16'h8003);
        check("par_accept_word", disp_word, 15'h0003);
        check("par_accept_strobe", disp_strobe, 1'b1);
        read_ch(DISP_CH);
        check("par_read", ch_rdata, 16'h8003);
`else
        write_ch(DISP_CH, 16'h0123);
        check("disp_word", disp_word, 15'h0123);
        check("disp_strobe", disp_strobe, 1'b1);
        idle();
        check("disp_strobe_end", disp_strobe, 1'b0);
        read_ch(DISP_CH);
        check("disp_read", ch_rdata, 16'h0123);
        write_ch(DISP_CH, 16'h8123);
        check("par_ignored", parity_err, 1'b0);
`endif
        write_ch(5, 16'h7fff);
        check("other_ch_write", disp_strobe, 1'b0);

        // Reset in the middle of a serviced interrupt with keys pending.
        push(5'h0a);
        push(5'h0b);
        idle();
        check("kr_pending", keyrupt, 1'b1);
        ack();
        async_reset("rst_mid");
        read_ch(KEY_CH);
        check("read_after_rst", ch_rdata[14:0], 15'd0);

        // Randomized traffic.
        async_reset("rst_rand");
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 5);
            wd = 16'($urandom);
            cyc(($urandom_range(0, 1) == 1), 5'($urandom), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0),
                (r < 3) ? 7'(KEY_CH) : (r < 5) ? 7'(DISP_CH) : 7'($urandom),
                wd, ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
